// File: rtl/alu_core.sv
// rtl/alu_core.sv - 8-bit operand ALU with iterative shift-add multiply feeding the result latch
// Optional ALU_FAST_MUL_EN: single-cycle combinational multiply instead of the WIDTH-cycle loop.
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 load_a,
    input  logic                 load_b,
    input  logic [2:0]           opcode,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   alu_result,
    output logic [2:0]           flags_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [2:0]           flags_q, flags_d;
    logic                 done_q, done_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     low;
    logic                 low_carry;
    logic [2*WIDTH-1:0]   op_result;
    logic [2:0]           op_flags;
    logic [2*WIDTH-1:0]   addend, prod_next;

    // Multiply flags look at the full product; non-MUL flags at the low half only.
    function automatic logic [2:0] mul_flags(input logic [2*WIDTH-1:0] p);
        return {(p == '0), (|p[2*WIDTH-1:WIDTH]), p[2*WIDTH-1]};
    endfunction

    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} - {1'b0, b_q};
        low       = '0;
        low_carry = 1'b0;
        op_result = '0;
        op_flags  = '0;
        case (opcode)
            3'b000:  begin low = sum[WIDTH-1:0];  low_carry = sum[WIDTH];  end
            3'b001:  begin low = diff[WIDTH-1:0]; low_carry = diff[WIDTH]; end
            3'b010:  low = a_q & b_q;
            3'b011:  low = a_q | b_q;
            3'b100:  low = a_q ^ b_q;
            3'b101:  begin low = {a_q[WIDTH-2:0], 1'b0}; low_carry = a_q[WIDTH-1]; end
            3'b110:  begin low = {1'b0, a_q[WIDTH-1:1]}; low_carry = a_q[0];       end
            default: low = '0;
        endcase
        if (opcode == 3'b111) begin
`ifdef ALU_FAST_MUL_EN
            op_result = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`else
            op_result = '0;
`endif
            op_flags = mul_flags(op_result);
        end else begin
            op_result = {{WIDTH{1'b0}}, low};
            op_flags  = {(low == '0), low_carry, low[WIDTH-1]};
        end
    end

    always_comb begin
        addend    = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
        prod_next = prod_q + addend;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        case (state_q)
            S_IDLE: begin
                if (load_a) a_d = data_in;
                if (load_b) b_d = data_in;
                if (start) begin
`ifdef ALU_FAST_MUL_EN
                    result_d = op_result;
                    flags_d  = op_flags;
                    done_d   = 1'b1;
`else
                    if (opcode == 3'b111) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        prod_d  = '0;
                    end else begin
                        result_d = op_result;
                        flags_d  = op_flags;
                        done_d   = 1'b1;
                    end
`endif
                end
            end
            S_MUL: begin
                prod_d = prod_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_FINISH;
                    result_d = prod_next;
                    flags_d  = mul_flags(prod_next);
                    done_d   = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    assign busy       = (state_q == S_MUL);
    assign done       = done_q;
    assign alu_result = result_q;
    assign flags_out  = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking bench for alu_core against an arithmetic reference model
module tb_alu_core;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        load_a, load_b;
    logic [2:0]  opcode;
    logic        start;
    logic        busy, done;
    logic [15:0] alu_result;
    logic [2:0]  flags_out;
    logic [15:0] latch_q;

    int checks   = 0;
    int failures = 0;
    int ma = 0;
    int mb = 0;

    always #5 clock = ~clock;

    alu_core #(.WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_a     (load_a),
        .load_b     (load_b),
        .opcode     (opcode),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .alu_result (alu_result),
        .flags_out  (flags_out)
    );

    // Downstream result latch with grab tied to done.
    always @(posedge clock) if (done) latch_q <= alu_result;

    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int fl);
        int r, c, n, z;
        c = 0;
        case (op)
            0: begin r = a + b; c = (r > 255) ? 1 : 0; r = r % 256; end
            1: begin c = (a < b) ? 1 : 0; r = (a - b + 256) % 256; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin c = (a >= 128) ? 1 : 0; r = (a * 2) % 256; end
            6: begin c = a % 2; r = a / 2; end
            default: begin r = a * b; c = (r > 255) ? 1 : 0; end
        endcase
        n   = (op == 7) ? (r / 32768) % 2 : (r / 128) % 2;
        z   = (r == 0) ? 1 : 0;
        res = r;
        fl  = z * 4 + c * 2 + n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_av(input int v);
        data_in = v[7:0]; load_a = 1'b1; tick(); load_a = 1'b0; ma = v;
    endtask

    task automatic load_bv(input int v);
        data_in = v[7:0]; load_b = 1'b1; tick(); load_b = 1'b0; mb = v;
    endtask

    task automatic load_both(input int v);
        data_in = v[7:0]; load_a = 1'b1; load_b = 1'b1; tick();
        load_a = 1'b0; load_b = 1'b0; ma = v; mb = v;
    endtask

    task automatic wait_done(output int lat, output int nb);
        lat = 1; nb = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input int op, input string tag);
        int res, fl, lat, nb, exp_lat, exp_busy;
        model(op, ma, mb, res, fl);
        opcode = op[2:0]; start = 1'b1; tick(); start = 1'b0;
        wait_done(lat, nb);
        exp_lat = 1; exp_busy = 0;
`ifndef ALU_FAST_MUL_EN
        if (op == 7) begin exp_lat = 9; exp_busy = 8; end
`endif
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busy_cycles"}, nb, exp_busy);
        check({tag, ".result"}, {16'h0, alu_result}, res);
        check({tag, ".flags"}, {29'h0, flags_out}, fl);
        tick();
        check({tag, ".done_pulse"}, {31'h0, done}, 0);
    endtask

    initial begin
        int lat, nb, seen, a, b, op;
        reset = 1'b1; data_in = 8'h55; load_a = 1'b1; load_b = 1'b1;
        opcode = 3'b000; start = 1'b1;
        tick(); tick();
        check("rst.result", {16'h0, alu_result}, 0);
        check("rst.flags", {29'h0, flags_out}, 0);
        check("rst.busy", {31'h0, busy}, 0);
        check("rst.done", {31'h0, done}, 0);
        reset = 1'b0; load_a = 1'b0; load_b = 1'b0; start = 1'b0;
        tick(); tick();
        check("idle.result", {16'h0, alu_result}, 0);
        check("idle.done", {31'h0, done}, 0);

        load_av(8'hFE); load_bv(8'h03);
        run_op(0, "add_fe03");
        check("latch.hi", {24'h0, latch_q[15:8]}, 8'h00);
        check("latch.lo", {24'h0, latch_q[7:0]}, 8'h01);

        load_both(8'h05);
        run_op(1, "sub_eq");
        load_av(8'h80);
        run_op(5, "shl_80");
        load_av(8'h01);
        run_op(6, "shr_01");
        load_both(8'hFF);
        run_op(7, "mul_ffff");

        // Start coinciding with a load uses the pre-edge operand.
        load_av(8'h03); load_bv(8'h04);
        opcode = 3'b000; start = 1'b1; data_in = 8'h50; load_a = 1'b1;
        tick(); start = 1'b0; load_a = 1'b0;
        check("same_edge.result", {16'h0, alu_result}, 16'h0007);
        check("same_edge.done", {31'h0, done}, 1);
        ma = 8'h50;
        tick();
        run_op(0, "after_load");

        load_both(8'h10);
`ifndef ALU_FAST_MUL_EN
        opcode = 3'b111; start = 1'b1; tick(); start = 1'b0;
        tick();
        opcode = 3'b000; start = 1'b1; data_in = 8'hAA; load_a = 1'b1;
        tick(); start = 1'b0; load_a = 1'b0;
        wait_done(lat, nb);
        check("mul_ign.latency", lat, 7);
        check("mul_ign.result", {16'h0, alu_result}, 16'h0100);
        check("mul_ign.flags", {29'h0, flags_out}, 3'b010);
        tick();
        check("mul_ign.no_queue", {31'h0, done}, 0);
`else
        run_op(7, "mul_1010");
`endif
        run_op(0, "add_1010");

        load_both(8'hFF);
        opcode = 3'b111; start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        ma = 0; mb = 0;
        check("abort.busy", {31'h0, busy}, 0);
        check("abort.done", {31'h0, done}, 0);
        check("abort.result", {16'h0, alu_result}, 0);
        check("abort.flags", {29'h0, flags_out}, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) seen++;
            tick();
        end
        check("abort.no_done", seen, 0);

        for (int i = 0; i < 40; i++) begin
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            op = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                load_both(a);
            end else begin
                load_av(a); load_bv(b);
            end
            run_op(op, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
